// File: rtl/alu_share_arb_if.sv
// rtl/alu_share_arb_if.sv - request, ALU and response signal bundle for alu_share_arb
interface alu_share_arb_if #(
  parameter int WORD_W = 32,
  parameter int OP_W   = 4,
  parameter int NREQ   = 2,
  parameter int ID_W   = 2
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*WORD_W-1:0] req_a;
  logic [NREQ*WORD_W-1:0] req_b;
  logic [NREQ*OP_W-1:0]   req_op;
  logic [WORD_W-1:0]      alu_a;
  logic [WORD_W-1:0]      alu_b;
  logic [OP_W-1:0]        alu_op;
  logic [WORD_W-1:0]      alu_f;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [WORD_W-1:0]      resp_data;
  logic [ID_W-1:0]        resp_id;

  modport master (
    output req_valid, req_a, req_b, req_op, alu_f, resp_ready,
    input  req_ready, alu_a, alu_b, alu_op, resp_valid, resp_data, resp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, alu_f, resp_ready,
    output req_ready, alu_a, alu_b, alu_op, resp_valid, resp_data, resp_id
  );
endinterface

// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - shares one ALU among NREQ requesters with a 2-entry tagged response FIFO
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module alu_share_arb #(
  parameter int WORD_W = 32,
  parameter int OP_W   = 4,
  parameter int NREQ   = 2,
  parameter int ID_W   = 2
) (
  input logic            clk,
  input logic            rst_n,
  alu_share_arb_if.slave bus
);

  logic [1:0]        count_q, count_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [WORD_W-1:0] data_q [2];
  logic [WORD_W-1:0] data_d [2];
  logic [ID_W-1:0]   id_q [2];
  logic [ID_W-1:0]   id_d [2];

  logic              space;
  logic              grant;
  logic              pop;
  logic [ID_W-1:0]   winner;

`ifdef ALU_ARB_RR_EN
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   cand;
`endif

  // Count never exceeds 2, so a pending pop is the only way to accept while full.
  assign pop   = (count_q != 2'd0) && bus.resp_ready;
  assign space = (count_q < 2'd2) || bus.resp_ready;

  always_comb begin
    grant  = 1'b0;
    winner = '0;
`ifdef ALU_ARB_RR_EN
    cand   = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = ID_W'((int'(rr_ptr_q) + i) % NREQ);
      if (!grant && space && bus.req_valid[cand]) begin
        grant  = 1'b1;
        winner = cand;
      end
    end
`else
    for (int i = 0; i < NREQ; i++) begin
      if (!grant && space && bus.req_valid[i]) begin
        grant  = 1'b1;
        winner = ID_W'(i);
      end
    end
`endif
  end

  // Idle cycles present requester 0 operands with passa so the ALU sees a benign op.
  always_comb begin
    bus.req_ready = '0;
    bus.alu_a     = bus.req_a[WORD_W-1:0];
    bus.alu_b     = bus.req_b[WORD_W-1:0];
    bus.alu_op    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant && (winner == ID_W'(i))) begin
        bus.req_ready[i] = 1'b1;
        bus.alu_a        = bus.req_a[i*WORD_W +: WORD_W];
        bus.alu_b        = bus.req_b[i*WORD_W +: WORD_W];
        bus.alu_op       = bus.req_op[i*OP_W +: OP_W];
      end
    end
  end

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    data_d   = data_q;
    id_d     = id_q;
    if (grant) begin
      data_d[wr_ptr_q] = bus.alu_f;
      id_d[wr_ptr_q]   = winner;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({grant, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

`ifdef ALU_ARB_RR_EN
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant) begin
      rr_ptr_d = (winner == ID_W'(NREQ - 1)) ? '0 : winner + ID_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        id_q[i]   <= '0;
      end
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      data_q   <= data_d;
      id_q     <= id_d;
    end
  end

  assign bus.resp_valid = (count_q != 2'd0);
  assign bus.resp_data  = data_q[rd_ptr_q];
  assign bus.resp_id    = id_q[rd_ptr_q];

endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - scoreboard bench for alu_share_arb with a behavioural ALU
module tb_alu_share_arb;
  localparam int WORD_W = 32;
  localparam int OP_W   = 4;
  localparam int NREQ   = 2;
  localparam int ID_W   = 2;

  typedef struct {
    logic [WORD_W-1:0] data;
    logic [ID_W-1:0]   id;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_share_arb_if #(.WORD_W(WORD_W), .OP_W(OP_W), .NREQ(NREQ), .ID_W(ID_W)) bus ();

  alu_share_arb #(.WORD_W(WORD_W), .OP_W(OP_W), .NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [WORD_W-1:0] op_a [NREQ];
  logic [WORD_W-1:0] op_b [NREQ];
  logic [OP_W-1:0]   op_c [NREQ];
  logic [NREQ-1:0]   valid;
  logic              resp_rdy;
  exp_t              sb [$];
  exp_t              e;
  int                n_tests = 0;
  int                n_fail = 0;

  function automatic logic [WORD_W-1:0] alu_model(input logic [WORD_W-1:0] a, input logic [WORD_W-1:0] b,
                                                  input logic [OP_W-1:0] op);
    case (op)
      4'd0:    return a;
      4'd1:    return b;
      4'd2:    return a + b;
      4'd3:    return a - b;
      default: return a ^ b;
    endcase
  endfunction

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[i*WORD_W +: WORD_W] = op_a[i];
      bus.req_b[i*WORD_W +: WORD_W] = op_b[i];
      bus.req_op[i*OP_W +: OP_W]    = op_c[i];
    end
    bus.req_valid  = valid;
    bus.resp_ready = resp_rdy;
  end

  assign bus.alu_f = alu_model(bus.alu_a, bus.alu_b, bus.alu_op);

  // Scoreboard: pop/compare responses, then record accepted requests from bench operands.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.resp_valid && resp_rdy) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got data=%0h id=%0d, expected no response", bus.resp_data, bus.resp_id);
        end else begin
          e = sb.pop_front();
          if (bus.resp_data !== e.data || bus.resp_id !== e.id) begin
            n_fail++;
            $display("FAIL sb_resp: got data=%0h id=%0d, expected data=%0h id=%0d",
                     bus.resp_data, bus.resp_id, e.data, e.id);
          end
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (valid[i] && bus.req_ready[i]) begin
          sb.push_back('{alu_model(op_a[i], op_b[i], op_c[i]), ID_W'(i)});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    valid = '0;
    sb.delete();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %0b, expected 0", bus.resp_valid); end
    n_tests++; if (bus.resp_data !== '0) begin n_fail++; $display("FAIL reset_resp_data: got %0h, expected 0", bus.resp_data); end
    n_tests++; if (bus.resp_id !== '0) begin n_fail++; $display("FAIL reset_resp_id: got %0d, expected 0", bus.resp_id); end
    n_tests++; if (bus.req_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready: got %b, expected 00", bus.req_ready); end
    n_tests++; if (bus.alu_op !== '0) begin n_fail++; $display("FAIL reset_alu_op: got %0d, expected 0", bus.alu_op); end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    resp_rdy = 1'b1;
    valid = 2'b01; op_a[0] = 32'd5; op_b[0] = 32'd7; op_c[0] = 4'd2;
    @(negedge clk);
    n_tests++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL single_ready: got %b, expected 01", bus.req_ready); end
    n_tests++; if (bus.alu_a !== 32'd5) begin n_fail++; $display("FAIL single_alu_a: got %0d, expected 5", bus.alu_a); end
    n_tests++; if (bus.alu_b !== 32'd7) begin n_fail++; $display("FAIL single_alu_b: got %0d, expected 7", bus.alu_b); end
    n_tests++; if (bus.alu_op !== 4'd2) begin n_fail++; $display("FAIL single_alu_op: got %0d, expected 2", bus.alu_op); end
    step();
    valid = '0;
    @(negedge clk);
    n_tests++; if (bus.resp_valid !== 1'b1) begin n_fail++; $display("FAIL single_resp_valid: got %0b, expected 1", bus.resp_valid); end
    n_tests++; if (bus.resp_data !== 32'd12) begin n_fail++; $display("FAIL single_resp_data: got %0d, expected 12", bus.resp_data); end
    n_tests++; if (bus.resp_id !== 2'd0) begin n_fail++; $display("FAIL single_resp_id: got %0d, expected 0", bus.resp_id); end
    step();
    @(negedge clk);
    n_tests++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %0b, expected 0", bus.resp_valid); end
    step();
  endtask

  task automatic test_contention();
    int win;
    logic [NREQ-1:0] exp_rdy;
    apply_reset();
    resp_rdy = 1'b1;
    valid = 2'b11;
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        op_a[i] = $urandom; op_b[i] = $urandom; op_c[i] = 4'($urandom_range(0, 4));
      end
`ifdef ALU_ARB_RR_EN
      win = c % 2;
`else
      win = 0;
`endif
      exp_rdy = NREQ'(1) << win;
      @(negedge clk);
      n_tests++; if (bus.req_ready !== exp_rdy) begin n_fail++; $display("FAIL contention_grant[%0d]: got %b, expected %b", c, bus.req_ready, exp_rdy); end
      n_tests++; if (bus.alu_a !== op_a[win]) begin n_fail++; $display("FAIL contention_alu_a[%0d]: got %0h, expected %0h", c, bus.alu_a, op_a[win]); end
      step();
    end
    valid = '0;
    step();
    @(negedge clk);
    n_tests++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL contention_drain: got %0b, expected 0", bus.resp_valid); end
    step();
  endtask

  task automatic test_backpressure();
    resp_rdy = 1'b0;
    valid = 2'b10; op_a[1] = 32'd100; op_b[1] = 32'd1; op_c[1] = 4'd2;
    @(negedge clk);
    n_tests++; if (bus.req_ready !== 2'b10) begin n_fail++; $display("FAIL bp_first: got %b, expected 10", bus.req_ready); end
    step();
    op_a[1] = 32'd200; op_b[1] = 32'd50; op_c[1] = 4'd3;
    @(negedge clk);
    n_tests++; if (bus.req_ready !== 2'b10) begin n_fail++; $display("FAIL bp_second: got %b, expected 10", bus.req_ready); end
    step();
    op_a[1] = 32'd7; op_b[1] = 32'd9; op_c[1] = 4'd1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_tests++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL bp_full_ready[%0d]: got %b, expected 00", c, bus.req_ready); end
      n_tests++; if (bus.resp_data !== 32'd101 || bus.resp_id !== 2'd1) begin n_fail++; $display("FAIL bp_head[%0d]: got %0d/%0d, expected 101/1", c, bus.resp_data, bus.resp_id); end
      step();
    end
    resp_rdy = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.req_ready !== 2'b10) begin n_fail++; $display("FAIL bp_push_pop: got %b, expected 10", bus.req_ready); end
    step();
    valid = '0;
    @(negedge clk);
    n_tests++; if (bus.resp_data !== 32'd150) begin n_fail++; $display("FAIL bp_second_out: got %0d, expected 150", bus.resp_data); end
    step();
    @(negedge clk);
    n_tests++; if (bus.resp_data !== 32'd9 || bus.resp_id !== 2'd1) begin n_fail++; $display("FAIL bp_third_out: got %0d/%0d, expected 9/1", bus.resp_data, bus.resp_id); end
    step();
    @(negedge clk);
    n_tests++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %0b, expected 0", bus.resp_valid); end
    step();
  endtask

  task automatic test_full_pushpop();
    resp_rdy = 1'b0;
    valid = 2'b01; op_a[0] = 32'd1; op_b[0] = 32'd1; op_c[0] = 4'd2;
    step();
    op_a[0] = 32'd2; op_b[0] = 32'd2; op_c[0] = 4'd2;
    step();
    op_a[0] = 32'd10; op_b[0] = 32'd3; op_c[0] = 4'd3;
    resp_rdy = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL full_pp_ready: got %b, expected 01", bus.req_ready); end
    n_tests++; if (bus.resp_data !== 32'd2) begin n_fail++; $display("FAIL full_pp_head: got %0d, expected 2", bus.resp_data); end
    step();
    valid = '0;
    resp_rdy = 1'b0;
    op_a[0] = 32'd1; op_b[0] = 32'd1; op_c[0] = 4'd2;
    @(negedge clk);
    n_tests++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'd4) begin n_fail++; $display("FAIL full_pp_new_head: got %0b/%0d, expected 1/4", bus.resp_valid, bus.resp_data); end
    valid = 2'b01;
    #1;
    n_tests++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL full_pp_still_full: got %b, expected 00", bus.req_ready); end
    valid = '0;
    step();
    resp_rdy = 1'b1;
    step();
    @(negedge clk);
    n_tests++; if (bus.resp_data !== 32'd7 || bus.resp_id !== 2'd0) begin n_fail++; $display("FAIL full_pp_tail: got %0d/%0d, expected 7/0", bus.resp_data, bus.resp_id); end
    step();
    @(negedge clk);
    n_tests++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL full_pp_drain: got %0b, expected 0", bus.resp_valid); end
    step();
  endtask

  task automatic test_async_reset();
    resp_rdy = 1'b0;
    valid = 2'b01; op_a[0] = 32'd3; op_b[0] = 32'd4; op_c[0] = 4'd2;
    step();
    op_a[0] = 32'd5; op_b[0] = 32'd6;
    step();
    valid = '0;
    @(negedge clk);
    n_tests++; if (bus.resp_valid !== 1'b1) begin n_fail++; $display("FAIL arst_pre_valid: got %0b, expected 1", bus.resp_valid); end
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    n_tests++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL arst_resp_valid: got %0b, expected 0", bus.resp_valid); end
    n_tests++; if (bus.resp_data !== '0) begin n_fail++; $display("FAIL arst_resp_data: got %0h, expected 0", bus.resp_data); end
    step();
    rst_n = 1'b1;
    resp_rdy = 1'b1;
    valid = 2'b11;
    op_a[1] = 32'd77; op_b[1] = 32'd1; op_c[1] = 4'd2;
    @(negedge clk);
    n_tests++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL arst_first_grant: got %b, expected 01", bus.req_ready); end
    n_tests++; if (bus.alu_a !== 32'd5) begin n_fail++; $display("FAIL arst_alu_a: got %0d, expected 5", bus.alu_a); end
    step();
    valid = '0;
    step();
    step();
    @(negedge clk);
    n_tests++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL arst_drain: got %0b, expected 0", bus.resp_valid); end
    step();
  endtask

  task automatic test_idle();
    resp_rdy = 1'b1;
    valid = '0;
    op_a[0] = 32'hdead_beef; op_c[0] = 4'd3;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_tests++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL idle_ready[%0d]: got %b, expected 00", c, bus.req_ready); end
      n_tests++; if (bus.alu_op !== 4'd0) begin n_fail++; $display("FAIL idle_alu_op[%0d]: got %0d, expected 0", c, bus.alu_op); end
      n_tests++; if (bus.alu_a !== 32'hdead_beef) begin n_fail++; $display("FAIL idle_alu_a[%0d]: got %0h, expected deadbeef", c, bus.alu_a); end
      n_tests++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL idle_resp_valid[%0d]: got %0b, expected 0", c, bus.resp_valid); end
      step();
    end
  endtask

  initial begin
    valid = '0;
    resp_rdy = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = '0; op_b[i] = '0; op_c[i] = '0;
    end
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_full_pushpop();
    test_async_reset();
    test_idle();
    n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d pending, expected 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
